// File: rtl/wb_sdram_port_arbiter.sv
// rtl/wb_sdram_port_arbiter.sv - round-robin Wishbone B4 arbiter with bus watchdog for the SDRAM slave port
module wb_sdram_port_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic               wb_clk_o,
  input  logic               async_rst,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM*3-1:0]    m_cti_i,
  input  logic [NM*2-1:0]    m_bte_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  output logic [NM-1:0]      grant_o,
  output logic               timeout_o
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic [1:0]    r_state;
  logic [NM-1:0] r_grant;
  logic [LW-1:0] r_last;
  logic [TW-1:0] r_cnt;

  logic [LW:0]   w_sum;
  logic [LW-1:0] w_next;
  logic          w_own;
  logic          w_cyc_g;
  logic          w_stb_g;
  logic          w_expire;

  // Scan downward so the lowest offset from last+1 is the one that sticks.
  always_comb begin
    w_next = r_last;
    w_sum  = '0;
    for (int i = NM; i >= 1; i--) begin
      w_sum = {1'b0, r_last} + (LW+1)'(i);
      if (w_sum >= (LW+1)'(NM)) w_sum = w_sum - (LW+1)'(NM);
      if (m_cyc_i[w_sum[LW-1:0]]) w_next = w_sum[LW-1:0];
    end
  end

  assign w_own    = (r_state == S_OWN);
  assign w_cyc_g  = m_cyc_i[r_last];
  assign w_stb_g  = m_stb_i[r_last];
  assign w_expire = w_own && w_stb_g && (r_cnt == TW'(TIMEOUT - 1));

  assign grant_o   = r_grant;
  assign timeout_o = w_expire;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (w_own) begin
      s_cyc_o = w_cyc_g;
      s_stb_o = w_stb_g;
      s_we_o  = m_we_i[r_last];
      s_adr_o = m_adr_i[r_last*AW +: AW];
      s_dat_o = m_dat_i[r_last*DW +: DW];
      s_sel_o = m_sel_i[r_last*SW +: SW];
      s_cti_o = m_cti_i[r_last*3 +: 3];
      s_bte_o = m_bte_i[r_last*2 +: 2];
      m_dat_o = s_dat_i;
      // A late ack in the expiry cycle is dropped; the master sees only the error.
      m_ack_o[r_last] = s_ack_i && !w_expire;
      m_err_o[r_last] = s_err_i || w_expire;
    end
  end

  always_ff @(posedge wb_clk_o or posedge async_rst) begin
    if (async_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= LW'(NM - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|m_cyc_i) begin
            r_state <= S_OWN;
            r_last  <= w_next;
            r_grant <= NM'(1) << w_next;
          end
        end
        S_OWN: begin
          if (w_expire) begin
            r_state <= S_ABORT;
          end else if (!w_cyc_g) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        end
        S_ABORT: begin
          if (!w_cyc_g) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase

      if (!w_own || !w_stb_g || s_ack_i || s_err_i || w_expire) r_cnt <= '0;
      else r_cnt <= r_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_wb_sdram_port_arbiter.sv
// tb/tb_wb_sdram_port_arbiter.sv - directed self-checking bench for wb_sdram_port_arbiter
module tb_wb_sdram_port_arbiter;

  logic        clk;
  logic        async_rst;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [95:0] m_adr, m_dat;
  logic [11:0] m_sel;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack_o, m_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err;
  logic [2:0]  grant;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  wb_sdram_port_arbiter #(.NM(3), .AW(32), .DW(32), .TIMEOUT(16), .TW(5)) dut (
    .wb_clk_o (clk),
    .async_rst(async_rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_cti_i  (m_cti),
    .m_bte_i  (m_bte),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_cti_o  (s_cti_o),
    .s_bte_o  (s_bte_o),
    .s_dat_i  (s_dat),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .grant_o  (grant),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_read(input int k, input logic [31:0] d, input bit rereq);
    tick();
    check("rr_grant", 64'(grant), 64'(3'b001 << k));
    check("rr_scyc", 64'(s_cyc_o), 64'd1);
    s_ack = 1'b1;
    s_dat = d;
    #1;
    check("rr_ack", 64'(m_ack_o), 64'(3'b001 << k));
    check("rr_dat", 64'(m_dat_o), 64'(d));
    check("rr_err", 64'(m_err_o), 64'd0);
    tick();
    s_ack = 1'b0;
    s_dat = '0;
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    #1;
    check("rr_ack_off", 64'(m_ack_o), 64'd0);
    tick();
    check("rr_bubble", 64'(grant), 64'd0);
    check("rr_bubble_cyc", 64'(s_cyc_o), 64'd0);
    if (rereq) begin
      m_cyc[k] = 1'b1;
      m_stb[k] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    async_rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    #22;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_scyc", 64'(s_cyc_o), 64'd0);
    check("rst_mdat", 64'(m_dat_o), 64'd0);
    check("rst_ack", 64'(m_ack_o), 64'd0);
    tick();
    async_rst = 1'b0;

    // Round robin with all three masters requesting single reads.
    m_cyc = 3'b111;
    m_stb = 3'b111;
    single_read(0, 32'hDEADBEEF, 1'b1);
    single_read(1, 32'hCAFEF00D, 1'b0);
    single_read(2, 32'h0BADF00D, 1'b0);
    single_read(0, 32'h13579BDF, 1'b0);

    // Master 1 burst; master 0 must wait for release.
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    m_cti[5:3] = 3'b010;
    m_adr[63:32] = 32'h100;
    tick();
    check("bst_grant", 64'(grant), 64'b010);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[31:0] = 32'h40; m_dat[31:0] = 32'h12345678; m_sel[3:0] = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      m_adr[63:32] = 32'h100 + 32'(4 * i);
      m_cti[5:3] = (i == 7) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      s_dat = 32'(i);
      #1;
      check("bst_adr", 64'(s_adr_o), 64'(32'h100 + 32'(4 * i)));
      check("bst_ack", 64'(m_ack_o), 64'b010);
      if (i == 7) check("bst_cti_end", 64'(s_cti_o), 64'b111);
      tick();
    end
    s_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[5:3] = 3'b000;
    #1;
    check("bst_hold", 64'(grant), 64'b010);
    check("bst_cyc_drop", 64'(s_cyc_o), 64'd0);
    tick();
    check("bst_bubble", 64'(grant), 64'd0);
    tick();

    // Master 0 write, now granted.
    check("wr_grant", 64'(grant), 64'b001);
    check("wr_adr", 64'(s_adr_o), 64'h40);
    check("wr_dat", 64'(s_dat_o), 64'h12345678);
    check("wr_sel", 64'(s_sel_o), 64'b0011);
    check("wr_we", 64'(s_we_o), 64'd1);
    check("wr_stb", 64'(s_stb_o), 64'd1);
    s_ack = 1'b1;
    #1;
    check("wr_ack", 64'(m_ack_o), 64'b001);
    check("wr_err", 64'(m_err_o), 64'd0);
    tick();
    s_ack = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    tick();
    check("wr_idle", 64'(grant), 64'd0);

    // Slave error on master 2 is forwarded without losing the grant.
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    check("err_grant", 64'(grant), 64'b100);
    s_err = 1'b1;
    #1;
    check("err_fwd", 64'(m_err_o), 64'b100);
    check("err_noack", 64'(m_ack_o), 64'd0);
    tick();
    s_err = 1'b0;
    s_ack = 1'b1;
    #1;
    check("err_keep", 64'(grant), 64'b100);
    check("err_next_ack", 64'(m_ack_o), 64'b100);
    tick();
    s_ack = 1'b0;
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();

    // Watchdog: master 1 never acked, expiry on the 16th strobe cycle.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    check("to_grant", 64'(grant), 64'b010);
    repeat (14) tick();
    check("to_early_err", 64'(m_err_o), 64'd0);
    check("to_early_pulse", 64'(timeout), 64'd0);
    tick();
    s_ack = 1'b1;
    #1;
    check("to_pulse", 64'(timeout), 64'd1);
    check("to_err", 64'(m_err_o), 64'b010);
    check("to_ack_ignored", 64'(m_ack_o), 64'd0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    s_ack = 1'b0;
    #1;
    check("abt_cyc", 64'(s_cyc_o), 64'd0);
    check("abt_stb", 64'(s_stb_o), 64'd0);
    check("abt_pulse_off", 64'(timeout), 64'd0);
    check("abt_grant", 64'(grant), 64'b010);
    tick();
    check("abt_still", 64'(s_cyc_o), 64'd0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    check("abt_idle", 64'(grant), 64'd0);
    tick();
    check("abt_next", 64'(grant), 64'b001);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();

    // Asynchronous reset in the middle of a master 2 write.
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    tick();
    check("mr_grant", 64'(grant), 64'b100);
    check("mr_cyc", 64'(s_cyc_o), 64'd1);
    s_ack = 1'b1;
    #1;
    async_rst = 1'b1;
    #1;
    check("mr_rst_cyc", 64'(s_cyc_o), 64'd0);
    check("mr_rst_grant", 64'(grant), 64'd0);
    check("mr_rst_ack", 64'(m_ack_o), 64'd0);
    s_ack = 1'b0;
    tick();
    async_rst = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    check("mr_first", 64'(grant), 64'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
